// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: RV32I major opcodes,
// controller state encoding and register-usage decode helpers.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } ctrl_state_t;

  // Every opcode reads rs1 except the U-type and JAL formats, whose
  // rs1 field is immediate bits.
  function automatic logic uses_rs1(input logic [6:0] op);
    logic r;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL: r = 1'b0;
      OP_LOAD, OP_STORE, OP_BRANCH, OP_OP, OP_OPIMM, OP_JALR: r = 1'b1;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Only R-type, stores and branches carry a real rs2 field.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the ID and EX stages.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] id_inst,
  input  logic [31:0] ex_inst,
  output logic        lu_hazard
);

  logic [6:0] ex_op;
  logic [6:0] id_op;
  logic [4:0] ex_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       unused_bits;

  assign ex_op  = ex_inst[6:0];
  assign ex_rd  = ex_inst[11:7];
  assign id_op  = id_inst[6:0];
  assign id_rs1 = id_inst[19:15];
  assign id_rs2 = id_inst[24:20];

  assign unused_bits = ^{id_inst[31:25], id_inst[14:7], ex_inst[31:12]};

  // A load writing x0 never produces a value, so it never stalls.
  always_comb begin
    lu_hazard = 1'b0;
    if ((ex_op == OP_LOAD) && (ex_rd != 5'd0)) begin
      lu_hazard = ((ex_rd == id_rs1) && uses_rs1(id_op)) ||
                  ((ex_rd == id_rs2) && uses_rs2(id_op));
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: priority mux for pipeline register enables and
// flushes, memory-wait FSM with sticky timeout, and saturating perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      ex_inst,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic              lu_hazard;
  logic              freeze;
  logic              do_flush;
  logic              do_stall;

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  load_use_detect u_lu (
    .id_inst   (id_inst),
    .ex_inst   (ex_inst),
    .lu_hazard (lu_hazard)
  );

  assign freeze = mem_req & ~mem_ready;

  // Priority mux: reset, freeze, redirect, load-use, normal flow.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    do_flush     = 1'b0;
    do_stall     = 1'b0;
    if (rst) begin
      do_flush = 1'b0;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      do_flush    = 1'b1;
    end else if (lu_hazard) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      do_stall    = 1'b1;
    end
  end

  // Memory-wait FSM and next values of the counters.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          if (wait_cnt_q == WAIT_MAX) begin
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (do_stall && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (do_flush && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign mem_timeout = timeout_q;

endmodule
